mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have clk  in  1  rising-edge clock.
REQ-002 SHALL have reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have pc_imm_m  in  32  branch target from EX/MEM register.
REQ-004 SHALL have zero_m  in  1  ALU zero flag.
REQ-005 SHALL have alu_result_m  in  32  ALU result / effective address.
REQ-006 SHALL have read_data_2_m  in  32  store data.
REQ-007 SHALL have reg_write_m, mem_to_reg_m, branch_m, mem_read_m, mem_write_m  in  1 each  control bits.
REQ-008 SHALL have rd_m  in  5  destination register.
REQ-009 SHALL have inst_m  in  32  instruction; funct3 = inst_m[14:12].
REQ-010 SHALL have dmem_req, dmem_we  out  1 each  memory request, write enable.
REQ-011 SHALL have dmem_addr  out  32, dmem_wdata  out  32, dmem_wstrb  out  4  bus signals.
REQ-012 SHALL have dmem_ack  in  1, dmem_rdata  in  32  memory response.
REQ-013 SHALL have stall_m  out  1  hold request to upstream stages.
REQ-014 SHALL have pc_src  out  1, branch_target  out  32  branch redirect.
REQ-015 SHALL have reg_write_w, mem_to_reg_w  out  1 each; read_data_w, alu_result_w, inst_w  out  32 each; rd_w  out  5  MEM/WB register.

Function
REQ-016 SHALL implement FSM IDLE/WAIT; access = mem_read_m | mem_write_m.
REQ-017 IDLE with access: dmem_req=1 same cycle; ack same cycle -> stays IDLE; no ack -> WAIT.
REQ-018 WAIT: dmem_req=1 and addr/wdata/wstrb/we held stable until dmem_ack; ack -> IDLE.
REQ-019 stall_m SHALL equal access & ~dmem_ack (combinational); upstream holds EX/MEM while high.
REQ-020 While stall_m=1, MEM/WB SHALL load a bubble: reg_write_w=0, mem_to_reg_w=0, inst_w=0.
REQ-021 When stall_m=0, MEM/WB SHALL capture alu_result_m, rd_m, inst_m, control bits, and extended load data on the rising edge (1-cycle latency).
REQ-022 dmem_addr SHALL be {alu_result_m[31:2],2'b00}; lane = alu_result_m[1:0].
REQ-023 Loads: LB/LH/LW/LBU/LHU (funct3 000/001/010/100/101) SHALL select lane and sign/zero-extend into read_data_w; other funct3 -> full word.
REQ-024 Stores: SB wstrb=0001<<lane, wdata byte replicated x4; SH wstrb=0011<<(lane&2), halfword replicated x2; SW wstrb=1111; dmem_wstrb=0 on reads.
REQ-025 pc_src SHALL be branch_m & (funct3==001 ? ~zero_m : zero_m), combinational, independent of stall; branch_target = pc_imm_m.
REQ-026 Load and store together (both bits set) SHALL be treated as store.

Reset
REQ-027 On reset, state SHALL go to IDLE and all MEM/WB outputs to 0.
REQ-028 Reset during WAIT SHALL abandon the access; dmem_req low in the cycle after reset is sampled unless a new access is presented.
REQ-029 Combinational outputs SHALL depend only on current inputs and state.

Configuration
REQ-030 MISALIGN_TRAP_EN defined: extra output misalign_w (1 bit); misaligned LH/LHU/SH (lane[0]=1) or LW/SW (lane!=0) SHALL not assert dmem_req, SHALL not stall, and SHALL register reg_write_w=0, misalign_w=1 for one cycle.
REQ-031 MISALIGN_TRAP_EN undefined: no misalign_w port; lane bits below natural alignment ignored (half uses lane&2, word uses 0) and access issued normally.

Structure
REQ-032 Shared package SHALL hold funct3 load/store/branch constants and the FSM state enum.
REQ-033 One sub-module, load_store_align, SHALL contain combinational lane selection, extension, and store replication/strobes.

Verification
REQ-034 LW, alu=0x100, ack same cycle, rdata=0xDEADBEEF -> no stall; next cycle read_data_w=0xDEADBEEF, mem_to_reg_w=1.
REQ-035 LB, alu=0x103, rdata=0x80xxxxxx, ack after 3 cycles -> stall_m=1 for 3 cycles with bubbles; then read_data_w=0xFFFFFF80.
REQ-036 SH, alu=0x202, rs2=0x0000ABCD -> dmem_we=1, wstrb=1100, wdata=0xABCDABCD, addr=0x200.
REQ-037 BNE branch_m=1, zero_m=0, pc_imm_m=0x40 -> pc_src=1, branch_target=0x40; zero_m=1 -> pc_src=0.
REQ-038 Reset asserted in WAIT -> next cycle state IDLE, dmem_req=0 (no access presented), reg_write_w=0.
REQ-039 With MISALIGN_TRAP_EN, LW alu=0x101 -> dmem_req=0, stall_m=0, next cycle misalign_w=1, reg_write_w=0.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Holds the funct3 encodings for loads, stores and branches, and the
// state type of the memory-access FSM.
package mem_access_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_access_stage_load_store_align.sv
// Byte-lane handling between the core and the 32-bit data bus.
// Loads: lane select plus sign/zero extension. Stores: data replication
// and byte strobes. Lane bits below natural alignment are ignored.
// Optional macro MISALIGN_TRAP_EN adds the `misaligned` detection output.
module load_store_align
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic        is_store,
  input  logic [31:0] rdata,
  input  logic [31:0] store_src,
  output logic [31:0] load_data,
  output logic [31:0] store_data,
  output logic [3:0]  store_strb
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/halfword and extend it into a full word.
  always_comb begin
    byte_sel = rdata[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   load_data = rdata;
      F3_LBU:  load_data = {24'h000000, byte_sel};
      F3_LHU:  load_data = {16'h0000, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Replicate store data across the bus and raise the matching strobes.
  always_comb begin
    case (funct3)
      F3_SB: begin
        store_data = {4{store_src[7:0]}};
        store_strb = 4'b0001 << lane;
      end
      F3_SH: begin
        store_data = {2{store_src[15:0]}};
        store_strb = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_data = store_src;
        store_strb = 4'b1111;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  // Halfwords need lane[0]==0, words need lane==0.
  always_comb begin
    if (is_store) begin
      misaligned = ((funct3 == F3_SH) && lane[0]) ||
                   ((funct3 == F3_SW) && (lane != 2'b00));
    end else begin
      misaligned = (((funct3 == F3_LH) || (funct3 == F3_LHU)) && lane[0]) ||
                   ((funct3 == F3_LW) && (lane != 2'b00));
    end
  end
`endif

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls upstream until
// the memory acknowledges, resolves branches, and holds the MEM/WB register.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses are not
// issued and are reported on misalign_w instead.
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_imm_m,
  input  logic        zero_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] read_data_2_m,
  input  logic        reg_write_m,
  input  logic        mem_to_reg_m,
  input  logic        branch_m,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [4:0]  rd_m,
  input  logic [31:0] inst_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_m,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        reg_write_w,
  output logic        mem_to_reg_w,
  output logic [31:0] read_data_w,
  output logic [31:0] alu_result_w,
  output logic [4:0]  rd_w,
  output logic [31:0] inst_w
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_w
`endif
);

  logic [2:0]  funct3;
  logic [1:0]  lane;
  logic        access_raw;
  logic        access;
  logic [31:0] load_data;
  logic [31:0] store_data;
  logic [3:0]  store_strb;
  logic [31:0] cur_addr;
  logic [3:0]  cur_wstrb;
  logic        we_sel;

  mem_state_e  state_q, state_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic [31:0] hold_wdata_q, hold_wdata_d;
  logic [3:0]  hold_wstrb_q, hold_wstrb_d;
  logic        hold_we_q, hold_we_d;

  logic        wb_reg_write_q, wb_reg_write_d;
  logic        wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [31:0] wb_read_data_q, wb_read_data_d;
  logic [31:0] wb_alu_result_q, wb_alu_result_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_inst_q, wb_inst_d;

  assign funct3     = inst_m[14:12];
  assign lane       = alu_result_m[1:0];
  assign access_raw = mem_read_m | mem_write_m;

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  logic trap;
  logic wb_misalign_q, wb_misalign_d;
  assign trap   = access_raw & misaligned;
  assign access = access_raw & ~misaligned;
`else
  assign access = access_raw;
`endif

  load_store_align u_align (
    .funct3     (funct3),
    .lane       (lane),
    .is_store   (mem_write_m),
    .rdata      (dmem_rdata),
    .store_src  (read_data_2_m),
    .load_data  (load_data),
    .store_data (store_data),
    .store_strb (store_strb)
`ifdef MISALIGN_TRAP_EN
    ,
    .misaligned (misaligned)
`endif
  );

  // A set write bit wins over the read bit, so load+store behaves as a store.
  assign cur_addr  = {alu_result_m[31:2], 2'b00};
  assign cur_wstrb = mem_write_m ? store_strb : 4'b0000;

  assign stall_m       = access & ~dmem_ack;
  assign pc_src        = branch_m & ((funct3 == F3_BNE) ? ~zero_m : zero_m);
  assign branch_target = pc_imm_m;

  // Request FSM: issue in IDLE, replay the captured bus beat while in WAIT.
  always_comb begin
    state_d      = state_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_wstrb_d = hold_wstrb_q;
    hold_we_d    = hold_we_q;
    dmem_req     = 1'b0;
    dmem_addr    = cur_addr;
    dmem_wdata   = store_data;
    dmem_wstrb   = cur_wstrb;
    we_sel       = mem_write_m;
    case (state_q)
      ST_IDLE: begin
        dmem_req     = access;
        hold_addr_d  = cur_addr;
        hold_wdata_d = store_data;
        hold_wstrb_d = cur_wstrb;
        hold_we_d    = mem_write_m;
        if (access && !dmem_ack) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        dmem_req   = 1'b1;
        dmem_addr  = hold_addr_q;
        dmem_wdata = hold_wdata_q;
        dmem_wstrb = hold_wstrb_q;
        we_sel     = hold_we_q;
        if (dmem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    dmem_we = dmem_req & we_sel;
    if (!dmem_req) dmem_wstrb = 4'b0000;
  end

  // MEM/WB next value: bubble while stalled, otherwise capture the stage.
  always_comb begin
    wb_reg_write_d  = wb_reg_write_q;
    wb_mem_to_reg_d = wb_mem_to_reg_q;
    wb_read_data_d  = wb_read_data_q;
    wb_alu_result_d = wb_alu_result_q;
    wb_rd_d         = wb_rd_q;
    wb_inst_d       = wb_inst_q;
`ifdef MISALIGN_TRAP_EN
    wb_misalign_d   = 1'b0;
`endif
    if (stall_m) begin
      wb_reg_write_d  = 1'b0;
      wb_mem_to_reg_d = 1'b0;
      wb_inst_d       = '0;
    end else begin
      wb_reg_write_d  = reg_write_m;
      wb_mem_to_reg_d = mem_to_reg_m;
      wb_read_data_d  = load_data;
      wb_alu_result_d = alu_result_m;
      wb_rd_d         = rd_m;
      wb_inst_d       = inst_m;
`ifdef MISALIGN_TRAP_EN
      if (trap) wb_reg_write_d = 1'b0;
      wb_misalign_d = trap;
`endif
    end
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      hold_addr_q     <= '0;
      hold_wdata_q    <= '0;
      hold_wstrb_q    <= '0;
      hold_we_q       <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_read_data_q  <= '0;
      wb_alu_result_q <= '0;
      wb_rd_q         <= '0;
      wb_inst_q       <= '0;
`ifdef MISALIGN_TRAP_EN
      wb_misalign_q   <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      hold_addr_q     <= hold_addr_d;
      hold_wdata_q    <= hold_wdata_d;
      hold_wstrb_q    <= hold_wstrb_d;
      hold_we_q       <= hold_we_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_read_data_q  <= wb_read_data_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_rd_q         <= wb_rd_d;
      wb_inst_q       <= wb_inst_d;
`ifdef MISALIGN_TRAP_EN
      wb_misalign_q   <= wb_misalign_d;
`endif
    end
  end

  assign reg_write_w  = wb_reg_write_q;
  assign mem_to_reg_w = wb_mem_to_reg_q;
  assign read_data_w  = wb_read_data_q;
  assign alu_result_w = wb_alu_result_q;
  assign rd_w         = wb_rd_q;
  assign inst_w       = wb_inst_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign_w   = wb_misalign_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a table of directed vectors,
// hand-written multi-cycle sequences, and randomized transactions checked
// against an arithmetic model of the load/store/branch rules.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic [31:0] pc_imm_m;
  logic        zero_m;
  logic [31:0] alu_result_m;
  logic [31:0] read_data_2_m;
  logic        reg_write_m, mem_to_reg_m, branch_m, mem_read_m, mem_write_m;
  logic [4:0]  rd_m;
  logic [31:0] inst_m;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_m, pc_src;
  logic [31:0] branch_target;
  logic        reg_write_w, mem_to_reg_w;
  logic [31:0] read_data_w, alu_result_w, inst_w;
  logic [4:0]  rd_w;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_w;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  mem_access_stage dut (
    .clk           (clk),
    .reset         (reset),
    .pc_imm_m      (pc_imm_m),
    .zero_m        (zero_m),
    .alu_result_m  (alu_result_m),
    .read_data_2_m (read_data_2_m),
    .reg_write_m   (reg_write_m),
    .mem_to_reg_m  (mem_to_reg_m),
    .branch_m      (branch_m),
    .mem_read_m    (mem_read_m),
    .mem_write_m   (mem_write_m),
    .rd_m          (rd_m),
    .inst_m        (inst_m),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_wstrb    (dmem_wstrb),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .stall_m       (stall_m),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .reg_write_w   (reg_write_w),
    .mem_to_reg_w  (mem_to_reg_w),
    .read_data_w   (read_data_w),
    .alu_result_w  (alu_result_w),
    .rd_w          (rd_w),
    .inst_w        (inst_w)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_w    (misalign_w)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] lane,
                                         input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * 32'(lane))) % 256;
    h = (w >> (16 * (32'(lane) / 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      3'd0:    return 4'(32'd1 << lane);
      3'd1:    return 4'(32'd3 << (2 * (32'(lane) / 2)));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3)
      3'd0:    return (rs2 % 256) * 32'h0101_0101;
      3'd1:    return (rs2 % 65536) * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  function automatic logic m_misaligned(input logic [2:0] f3, input logic [1:0] lane,
                                        input logic is_store);
`ifdef MISALIGN_TRAP_EN
    logic half;
    half = is_store ? (f3 == 3'd1) : (f3 == 3'd1 || f3 == 3'd5);
    return (half && (lane % 2 == 1)) || ((f3 == 3'd2) && (lane != 0));
`else
    return 1'b0 & f3[0] & lane[0] & is_store;
`endif
  endfunction

  task automatic drive(input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic mr, input logic mw, input logic rw,
                       input logic m2r, input logic br, input logic zr, input logic [31:0] pcimm);
    inst_m        = ($urandom() & 32'hFFFF_8FFF) | (32'(f3) << 12);
    alu_result_m  = alu;
    read_data_2_m = rs2;
    rd_m          = rd;
    mem_read_m    = mr;
    mem_write_m   = mw;
    reg_write_m   = rw;
    mem_to_reg_m  = m2r;
    branch_m      = br;
    zero_m        = zr;
    pc_imm_m      = pcimm;
  endtask

  task automatic idle_inputs();
    drive(3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
  endtask

  // One randomized transaction, ack after `delay` cycles if it accesses memory.
  task automatic run_txn(input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [31:0] rdata, input logic [31:0] pcimm, input logic [4:0] rd,
                         input logic mr, input logic mw, input logic rw, input logic m2r,
                         input logic br, input logic zr, input int unsigned delay);
    logic mis, acc, ackn;
    logic [31:0] inst;
    int unsigned d;
    drive(f3, alu, rs2, rd, mr, mw, rw, m2r, br, zr, pcimm);
    inst = inst_m;
    mis  = m_misaligned(f3, alu[1:0], mw);
    acc  = (mr | mw) & ~mis;
    d    = acc ? delay : 0;
    for (int unsigned c = 0; c <= d; c++) begin
      ackn       = acc && (c == d);
      dmem_ack   = acc ? ackn : 1'($urandom_range(0, 1));
      dmem_rdata = (c == d) ? rdata : $urandom();
      @(negedge clk);
      chk("stall_m", 32'(stall_m), 32'(acc & ~ackn));
      chk("dmem_req", 32'(dmem_req), 32'(acc));
      chk("pc_src", 32'(pc_src), 32'(br & ((f3 == 3'd1) ? ~zr : zr)));
      chk("branch_target", branch_target, pcimm);
      if (acc) begin
        chk("dmem_addr", dmem_addr, alu & 32'hFFFF_FFFC);
        chk("dmem_we", 32'(dmem_we), 32'(mw));
        chk("dmem_wstrb", 32'(dmem_wstrb), mw ? 32'(m_strb(f3, alu[1:0])) : 32'h0);
        if (mw) chk("dmem_wdata", dmem_wdata, m_wdata(f3, rs2));
      end
      @(posedge clk);
      #1;
      if (acc && !ackn) begin
        chk("bubble reg_write_w", 32'(reg_write_w), 32'h0);
        chk("bubble mem_to_reg_w", 32'(mem_to_reg_w), 32'h0);
        chk("bubble inst_w", inst_w, 32'h0);
`ifdef MISALIGN_TRAP_EN
        chk("bubble misalign_w", 32'(misalign_w), 32'h0);
`endif
      end else begin
        chk("reg_write_w", 32'(reg_write_w), 32'(rw & ~mis));
        chk("mem_to_reg_w", 32'(mem_to_reg_w), 32'(m2r));
        chk("rd_w", 32'(rd_w), 32'(rd));
        chk("inst_w", inst_w, inst);
        chk("alu_result_w", alu_result_w, alu);
        chk("read_data_w", read_data_w, m_load(f3, alu[1:0], rdata));
`ifdef MISALIGN_TRAP_EN
        chk("misalign_w", 32'(misalign_w), 32'(mis));
`endif
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] alu, rs2, rdata;
    logic        mr, mw;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_rdw;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{"LW",    3'd0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1, 0, 32'h100, 0, 4'b0000, 32'h0, 32'hDEAD_BEEF};
    vt[0].f3 = 3'd2;
    vt[1] = '{"SH",    3'd1, 32'h0000_0202, 32'h0000_ABCD, 32'h1234_5678, 0, 1, 32'h200, 1, 4'b1100, 32'hABCD_ABCD, 32'h0000_1234};
    vt[2] = '{"LBU",   3'd4, 32'h0000_0101, 32'h0, 32'h1122_8344, 1, 0, 32'h100, 0, 4'b0000, 32'h0, 32'h0000_0083};
    vt[3] = '{"LHU",   3'd5, 32'h0000_0102, 32'h0, 32'h9ABC_0000, 1, 0, 32'h100, 0, 4'b0000, 32'h0, 32'h0000_9ABC};
    vt[4] = '{"LH",    3'd1, 32'h0000_0100, 32'h0, 32'h0000_F00D, 1, 0, 32'h100, 0, 4'b0000, 32'h0, 32'hFFFF_F00D};
    vt[5] = '{"SB",    3'd0, 32'h0000_0303, 32'h0000_00A5, 32'h0, 0, 1, 32'h300, 1, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    vt[6] = '{"SW",    3'd2, 32'h0000_040C, 32'hCAFE_F00D, 32'h0102_0304, 0, 1, 32'h40C, 1, 4'b1111, 32'hCAFE_F00D, 32'h0102_0304};
    vt[7] = '{"LD+ST", 3'd2, 32'h0000_0010, 32'h55AA_55AA, 32'h7777_7777, 1, 1, 32'h010, 1, 4'b1111, 32'h55AA_55AA, 32'h7777_7777};

    // Reset state.
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst reg_write_w", 32'(reg_write_w), 32'h0);
    chk("rst mem_to_reg_w", 32'(mem_to_reg_w), 32'h0);
    chk("rst read_data_w", read_data_w, 32'h0);
    chk("rst alu_result_w", alu_result_w, 32'h0);
    chk("rst rd_w", 32'(rd_w), 32'h0);
    chk("rst inst_w", inst_w, 32'h0);
    chk("rst dmem_req", 32'(dmem_req), 32'h0);
    chk("rst stall_m", 32'(stall_m), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed vectors, memory acknowledges in the same cycle.
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].f3, vt[i].alu, vt[i].rs2, 5'd7, vt[i].mr, vt[i].mw, vt[i].mr & ~vt[i].mw,
            vt[i].mr, 1'b0, 1'b0, 32'h0);
      dmem_ack   = 1'b1;
      dmem_rdata = vt[i].rdata;
      @(negedge clk);
      chk({vt[i].name, " stall_m"}, 32'(stall_m), 32'h0);
      chk({vt[i].name, " dmem_req"}, 32'(dmem_req), 32'h1);
      chk({vt[i].name, " dmem_addr"}, dmem_addr, vt[i].e_addr);
      chk({vt[i].name, " dmem_we"}, 32'(dmem_we), 32'(vt[i].e_we));
      chk({vt[i].name, " dmem_wstrb"}, 32'(dmem_wstrb), 32'(vt[i].e_strb));
      if (vt[i].e_we) chk({vt[i].name, " dmem_wdata"}, dmem_wdata, vt[i].e_wdata);
      @(posedge clk);
      #1;
      chk({vt[i].name, " read_data_w"}, read_data_w, vt[i].e_rdw);
      chk({vt[i].name, " mem_to_reg_w"}, 32'(mem_to_reg_w), 32'(vt[i].mr));
      chk({vt[i].name, " reg_write_w"}, 32'(reg_write_w), 32'(vt[i].mr & ~vt[i].mw));
    end

    // LB with ack after three wait cycles.
    drive(3'd0, 32'h0000_0103, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c <= 3; c++) begin
      dmem_ack   = (c == 3);
      dmem_rdata = (c == 3) ? 32'h8012_3456 : 32'h0;
      @(negedge clk);
      chk("LB-wait stall_m", 32'(stall_m), (c == 3) ? 32'h0 : 32'h1);
      chk("LB-wait dmem_req", 32'(dmem_req), 32'h1);
      chk("LB-wait dmem_addr", dmem_addr, 32'h0000_0100);
      @(posedge clk);
      #1;
      if (c < 3) begin
        chk("LB-wait bubble reg_write_w", 32'(reg_write_w), 32'h0);
        chk("LB-wait bubble inst_w", inst_w, 32'h0);
      end else begin
        chk("LB-wait read_data_w", read_data_w, 32'hFFFF_FF80);
        chk("LB-wait reg_write_w", 32'(reg_write_w), 32'h1);
      end
    end

    // Branch resolution.
    drive(3'd1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040);
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("BNE taken pc_src", 32'(pc_src), 32'h1);
    chk("BNE branch_target", branch_target, 32'h0000_0040);
    zero_m = 1'b1;
    #1;
    chk("BNE not-taken pc_src", 32'(pc_src), 32'h0);
    inst_m = inst_m & 32'hFFFF_8FFF;
    #1;
    chk("BEQ taken pc_src", 32'(pc_src), 32'h1);
    @(posedge clk);
    #1;

    // Reset while waiting abandons the access.
    drive(3'd2, 32'h0000_0100, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("RW stall_m", 32'(stall_m), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("RW dmem_req in WAIT", 32'(dmem_req), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("RW dmem_req after reset", 32'(dmem_req), 32'h0);
    chk("RW stall_m after reset", 32'(stall_m), 32'h0);
    chk("RW reg_write_w", 32'(reg_write_w), 32'h0);
    chk("RW inst_w", inst_w, 32'h0);
    @(posedge clk);
    #1;

`ifdef MISALIGN_TRAP_EN
    // Misaligned word load is trapped rather than issued.
    drive(3'd2, 32'h0000_0101, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("MIS dmem_req", 32'(dmem_req), 32'h0);
    chk("MIS stall_m", 32'(stall_m), 32'h0);
    @(posedge clk);
    #1;
    chk("MIS misalign_w", 32'(misalign_w), 32'h1);
    chk("MIS reg_write_w", 32'(reg_write_w), 32'h0);
    idle_inputs();
    @(posedge clk);
    #1;
    chk("MIS misalign_w clears", 32'(misalign_w), 32'h0);
`endif

    // Randomized transactions.
    for (int n = 0; n < 400; n++) begin
      int unsigned kind;
      logic [2:0] f3;
      logic mr, mw;
      kind = $urandom_range(0, 3);
      mr   = (kind == 1) || (kind == 3);
      mw   = (kind == 2) || (kind == 3);
      f3   = mw ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      run_txn(f3, $urandom(), $urandom(), $urandom(), $urandom(), 5'($urandom()),
              mr, mw, 1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()),
              $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
